dsp_mac_sequencer: RTL and testbench



---
 rtl/dsp_seq_pkg.sv | 29 ++
 rtl/dsp_seq_token_pipe.sv | 36 +++
 rtl/dsp_mac_sequencer.sv | 169 ++++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared types, OPMODE constants and pipe-depth helpers for the DSP48A1 MAC sequencer.
`timescale 1ns/1ps
package dsp_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // X=M, Z=P, add
  localparam logic [7:0] OPMODE_MAC  = 8'h09;
  localparam logic [7:0] OPMODE_IDLE = 8'h00;

  function automatic int unsigned calc_depth(input int unsigned abreg,
                                             input int unsigned mreg,
                                             input int unsigned preg);
    return abreg + mreg + preg;
  endfunction

  // Selects token bits 1..d-2: stages that still have a later stage in front of P.
  function automatic logic [31:0] inner_mask(input int unsigned d);
    if (d < 3) return 32'd0;
    return ((32'd1 << (d - 1)) - 32'd1) & ~32'd1;
  endfunction

endpackage

// File: rtl/dsp_seq_token_pipe.sv
// D-stage valid-token shift register; bit k is the CE for the k-th present datapath stage.
`timescale 1ns/1ps
module dsp_seq_token_pipe #(
  parameter int unsigned D = 3
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         flush,
  input  logic         accept,
  output logic [D-1:0] tok
);

  generate
    if (D == 1) begin : g_comb_only
      assign tok = accept;
    end else begin : g_regs
      logic [D-2:0] pipe_q;

      if (D == 2) begin : g_one
        always_ff @(posedge CLK) begin
          if (rst || flush) pipe_q <= '0;
          else              pipe_q <= accept;
        end
      end else begin : g_many
        always_ff @(posedge CLK) begin
          if (rst || flush) pipe_q <= '0;
          else              pipe_q <= {pipe_q[D-3:0], accept};
        end
      end

      // Stage 0 is combinational on accept so the first register captures the pair it is offered.
      assign tok = {pipe_q, accept};
    end
  endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives CE/RST/OPMODE of a DSP48A1-style slice for one LEN-pair MAC job.
// Optional abort input enabled by defining DSP_SEQ_ABORT_EN.
`timescale 1ns/1ps
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 8,
  parameter int unsigned ABREG     = 1,
  parameter int unsigned MREG      = 1,
  parameter int unsigned PREG      = 1
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
`ifdef DSP_SEQ_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [1:0]           ce_ab,
  output logic                 ce_m,
  output logic                 ce_p,
  output logic                 rstp,
  output logic [7:0]           opmode,
  output logic                 done
);

  localparam int unsigned D          = calc_depth(ABREG, MREG, PREG);
  localparam logic [31:0] INNER_MASK = inner_mask(D);

  generate
    if (PREG != 1) begin : g_bad_preg
      $error("dsp_mac_sequencer: PREG must be 1, accumulation needs the P register");
    end
    if (ABREG > 2 || MREG > 1) begin : g_bad_regs
      $error("dsp_mac_sequencer: ABREG must be 0..2 and MREG 0..1");
    end
  endgenerate

  state_e               state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] count;
  logic [LEN_WIDTH-1:0] count_inc;
  logic                 accept;
  logic                 flush;
  logic [D-1:0]         tok;

`ifdef DSP_SEQ_ABORT_EN
  assign flush = abort && (state inside {CLEAR, FEED, DRAIN});
`else
  assign flush = 1'b0;
`endif

  assign accept    = in_valid && in_ready && !flush;
  assign count_inc = count + 1'b1;

  dsp_seq_token_pipe #(.D(D)) u_token_pipe (
    .CLK    (CLK),
    .rst    (rst),
    .flush  (flush),
    .accept (accept),
    .tok    (tok)
  );

  generate
    if (ABREG >= 1) begin : g_ab1
      assign ce_ab[0] = tok[0];
    end else begin : g_no_ab1
      assign ce_ab[0] = 1'b0;
    end
    if (ABREG == 2) begin : g_ab2
      assign ce_ab[1] = tok[1];
    end else begin : g_no_ab2
      assign ce_ab[1] = 1'b0;
    end
    if (MREG == 1) begin : g_m
      assign ce_m = tok[ABREG];
    end else begin : g_no_m
      assign ce_m = 1'b0;
    end
  endgenerate

  assign ce_p = tok[D-1];

  // NOTE: every control output is registered alongside the state it belongs to, so
  // in_ready/busy/opmode are computed for the state being entered, not the current one.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= '0;
      count    <= '0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
      rstp     <= 1'b0;
      opmode   <= OPMODE_IDLE;
      done     <= 1'b0;
    end else begin
      rstp <= 1'b0;
      done <= 1'b0;
      if (flush) begin
        state    <= IDLE;
        count    <= '0;
        busy     <= 1'b0;
        in_ready <= 1'b0;
        rstp     <= 1'b1;
        opmode   <= OPMODE_IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              len_q <= len;
              count <= '0;
              state <= CLEAR;
              busy  <= 1'b1;
              rstp  <= 1'b1;
            end
          end
          CLEAR: begin
            if (len_q == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= FEED;
              in_ready <= 1'b1;
              opmode   <= OPMODE_MAC;
            end
          end
          FEED: begin
            if (accept) begin
              count <= count_inc;
              if (count_inc == len_q) begin
                in_ready <= 1'b0;
                // With a single-stage pipe the last ce_p fires on the accept itself.
                if (D == 1) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  opmode <= OPMODE_IDLE;
                end else begin
                  state <= DRAIN;
                end
              end
            end
          end
          DRAIN: begin
            // Leave once only the P stage (or nothing) still holds a token.
            if ((tok & INNER_MASK[D-1:0]) == '0) begin
              state  <= DONE;
              done   <= 1'b1;
              opmode <= OPMODE_IDLE;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b0;
            opmode   <= OPMODE_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with ABREG=2, MREG=1, PREG=1 (pipe depth 4).
`timescale 1ns/1ps
module tb_dsp_mac_sequencer;

  logic       CLK = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       in_valid;
`ifdef DSP_SEQ_ABORT_EN
  logic       abort;
`endif
  logic       busy, in_ready, ce_m, ce_p, rstp, done;
  logic [1:0] ce_ab;
  logic [7:0] opmode;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-cycle traces: bit c is the signal's value in cycle c (cycle 0 = start driven).
  logic [31:0] m_rstp, m_acc, m_ce0, m_ce1, m_cem, m_cep, m_done, m_busy, m_mac, m_badop, m_zero;

  always #5 CLK = ~CLK;

  dsp_mac_sequencer #(
    .LEN_WIDTH (8),
    .ABREG     (2),
    .MREG      (1),
    .PREG      (1)
  ) dut (
    .CLK      (CLK),
    .rst      (rst),
    .start    (start),
    .len      (len),
`ifdef DSP_SEQ_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ce_ab    (ce_ab),
    .ce_m     (ce_m),
    .ce_p     (ce_p),
    .rstp     (rstp),
    .opmode   (opmode),
    .done     (done)
  );

  task automatic run(input int ncyc, input logic [7:0] l0, input logic [7:0] l1,
                     input logic [31:0] st, input logic [31:0] vl,
                     input logic [31:0] rs, input logic [31:0] ab);
    m_rstp = '0; m_acc = '0; m_ce0 = '0; m_ce1 = '0; m_cem = '0; m_cep = '0;
    m_done = '0; m_busy = '0; m_mac = '0; m_badop = '0; m_zero = '0;
    for (int c = 0; c < ncyc; c++) begin
      start    = st[c];
      in_valid = vl[c];
      rst      = rs[c];
      len      = (c == 0) ? l0 : l1;
`ifdef DSP_SEQ_ABORT_EN
      abort    = ab[c];
`else
      if (ab[c]) $display("note: abort requested at cycle %0d but port is absent", c);
`endif
      #1;
      m_rstp[c]  = rstp;
      m_acc[c]   = in_valid & in_ready;
      m_ce0[c]   = ce_ab[0];
      m_ce1[c]   = ce_ab[1];
      m_cem[c]   = ce_m;
      m_cep[c]   = ce_p;
      m_done[c]  = done;
      m_busy[c]  = busy;
      m_mac[c]   = (opmode == 8'h09);
      m_badop[c] = (opmode != 8'h09) && (opmode != 8'h00);
      m_zero[c]  = !(busy || in_ready || (|ce_ab) || ce_m || ce_p || rstp || (|opmode) || done);
      @(posedge CLK);
      #1;
    end
    start = 1'b0; in_valid = 1'b0; rst = 1'b0;
`ifdef DSP_SEQ_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; len = 8'd7;
`ifdef DSP_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL rst_busy got %b want 0", busy); n_bad++; end
    n_cmp++; if (in_ready !== 1'b0) begin $display("FAIL rst_in_ready got %b want 0", in_ready); n_bad++; end
    n_cmp++; if ({ce_ab, ce_m, ce_p} !== 4'b0) begin $display("FAIL rst_ce got %b want 0000", {ce_ab, ce_m, ce_p}); n_bad++; end
    n_cmp++; if (rstp !== 1'b0) begin $display("FAIL rst_rstp got %b want 0", rstp); n_bad++; end
    n_cmp++; if (opmode !== 8'h00) begin $display("FAIL rst_opmode got %h want 00", opmode); n_bad++; end
    n_cmp++; if (done !== 1'b0) begin $display("FAIL rst_done got %b want 0", done); n_bad++; end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_basic(input string tag);
    run(12, 8'd3, 8'd3, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0);
    n_cmp++; if (m_rstp !== 32'h002) begin $display("FAIL %s_rstp got %h want 002", tag, m_rstp); n_bad++; end
    n_cmp++; if (m_acc  !== 32'h01C) begin $display("FAIL %s_accept got %h want 01c", tag, m_acc); n_bad++; end
    n_cmp++; if (m_ce0  !== 32'h01C) begin $display("FAIL %s_ce_ab0 got %h want 01c", tag, m_ce0); n_bad++; end
    n_cmp++; if (m_ce1  !== 32'h038) begin $display("FAIL %s_ce_ab1 got %h want 038", tag, m_ce1); n_bad++; end
    n_cmp++; if (m_cem  !== 32'h070) begin $display("FAIL %s_ce_m got %h want 070", tag, m_cem); n_bad++; end
    n_cmp++; if (m_cep  !== 32'h0E0) begin $display("FAIL %s_ce_p got %h want 0e0", tag, m_cep); n_bad++; end
    n_cmp++; if (m_done !== 32'h100) begin $display("FAIL %s_done got %h want 100", tag, m_done); n_bad++; end
    n_cmp++; if (m_busy !== 32'h1FE) begin $display("FAIL %s_busy got %h want 1fe", tag, m_busy); n_bad++; end
    n_cmp++; if (m_mac  !== 32'h0FC) begin $display("FAIL %s_opmode_mac got %h want 0fc", tag, m_mac); n_bad++; end
    n_cmp++; if (m_badop !== 32'h0) begin $display("FAIL %s_opmode_other got %h want 0", tag, m_badop); n_bad++; end
    n_cmp++; if (m_zero !== 32'hE01) begin $display("FAIL %s_all_zero got %h want e01", tag, m_zero); n_bad++; end
  endtask

  task automatic test_bubble();
    run(14, 8'd4, 8'd4, 32'h1, ~32'h8, 32'h0, 32'h0);
    n_cmp++; if (m_acc  !== 32'h074) begin $display("FAIL bub_accept got %h want 074", m_acc); n_bad++; end
    n_cmp++; if (m_ce1  !== 32'h0E8) begin $display("FAIL bub_ce_ab1 got %h want 0e8", m_ce1); n_bad++; end
    n_cmp++; if (m_cem  !== 32'h1D0) begin $display("FAIL bub_ce_m got %h want 1d0", m_cem); n_bad++; end
    n_cmp++; if (m_cep  !== 32'h3A0) begin $display("FAIL bub_ce_p got %h want 3a0", m_cep); n_bad++; end
    n_cmp++; if (m_done !== 32'h400) begin $display("FAIL bub_done got %h want 400", m_done); n_bad++; end
    n_cmp++; if (m_busy !== 32'h7FE) begin $display("FAIL bub_busy got %h want 7fe", m_busy); n_bad++; end
    n_cmp++; if (m_mac  !== 32'h3FC) begin $display("FAIL bub_opmode_mac got %h want 3fc", m_mac); n_bad++; end
  endtask

  task automatic test_len_zero();
    run(8, 8'd0, 8'd0, 32'h1, 32'hFF, 32'h0, 32'h0);
    n_cmp++; if (m_rstp !== 32'h02) begin $display("FAIL len0_rstp got %h want 02", m_rstp); n_bad++; end
    n_cmp++; if (m_done !== 32'h04) begin $display("FAIL len0_done got %h want 04", m_done); n_bad++; end
    n_cmp++; if (m_busy !== 32'h06) begin $display("FAIL len0_busy got %h want 06", m_busy); n_bad++; end
    n_cmp++; if ((m_ce0 | m_ce1 | m_cem | m_cep) !== 32'h0) begin
      $display("FAIL len0_ce got %h want 0", m_ce0 | m_ce1 | m_cem | m_cep); n_bad++; end
    n_cmp++; if ((m_mac | m_badop) !== 32'h0) begin $display("FAIL len0_opmode got %h want 0", m_mac | m_badop); n_bad++; end
  endtask

  task automatic test_start_ignored();
    // start again in FEED (cycle 2) and DONE (cycle 7), with len changed to 5 after cycle 0
    run(14, 8'd2, 8'd5, 32'h085, 32'hFFFF, 32'h0, 32'h0);
    n_cmp++; if (m_acc  !== 32'h00C) begin $display("FAIL restart_accept got %h want 00c", m_acc); n_bad++; end
    n_cmp++; if (m_cep  !== 32'h060) begin $display("FAIL restart_ce_p got %h want 060", m_cep); n_bad++; end
    n_cmp++; if (m_done !== 32'h080) begin $display("FAIL restart_done got %h want 080", m_done); n_bad++; end
    n_cmp++; if (m_rstp !== 32'h002) begin $display("FAIL restart_rstp got %h want 002", m_rstp); n_bad++; end
    n_cmp++; if (m_busy !== 32'h0FE) begin $display("FAIL restart_busy got %h want 0fe", m_busy); n_bad++; end
  endtask

  task automatic test_rst_in_drain();
    run(12, 8'd3, 8'd3, 32'h1, 32'hFFFF_FFFF, 32'h040, 32'h0);
    n_cmp++; if (m_cep  !== 32'h060) begin $display("FAIL rstdrain_ce_p got %h want 060", m_cep); n_bad++; end
    n_cmp++; if (m_done !== 32'h000) begin $display("FAIL rstdrain_done got %h want 000", m_done); n_bad++; end
    n_cmp++; if (m_busy !== 32'h07E) begin $display("FAIL rstdrain_busy got %h want 07e", m_busy); n_bad++; end
    n_cmp++; if (m_zero !== 32'hF81) begin $display("FAIL rstdrain_all_zero got %h want f81", m_zero); n_bad++; end
    test_basic("after_rst");
  endtask

  task automatic test_abort();
`ifdef DSP_SEQ_ABORT_EN
    run(14, 8'd5, 8'd5, 32'h1, 32'hFFFF, 32'h0, 32'h8);
    n_cmp++; if (m_rstp !== 32'h012) begin $display("FAIL abort_rstp got %h want 012", m_rstp); n_bad++; end
    n_cmp++; if (((m_ce0 | m_ce1 | m_cem | m_cep) & ~32'hF) !== 32'h0) begin
      $display("FAIL abort_ce_after got %h want 0", (m_ce0 | m_ce1 | m_cem | m_cep) & ~32'hF); n_bad++; end
    n_cmp++; if (m_done !== 32'h000) begin $display("FAIL abort_done got %h want 000", m_done); n_bad++; end
    n_cmp++; if (m_busy !== 32'h00E) begin $display("FAIL abort_busy got %h want 00e", m_busy); n_bad++; end
    n_cmp++; if (m_mac  !== 32'h00C) begin $display("FAIL abort_opmode_mac got %h want 00c", m_mac); n_bad++; end
    test_basic("after_abort");
`else
    run(14, 8'd5, 8'd5, 32'h1, 32'hFFFF, 32'h0, 32'h0);
    n_cmp++; if (m_acc  !== 32'h07C) begin $display("FAIL len5_accept got %h want 07c", m_acc); n_bad++; end
    n_cmp++; if (m_cep  !== 32'h3E0) begin $display("FAIL len5_ce_p got %h want 3e0", m_cep); n_bad++; end
    n_cmp++; if (m_done !== 32'h400) begin $display("FAIL len5_done got %h want 400", m_done); n_bad++; end
`endif
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_bubble();
    test_len_zero();
    test_start_ignored();
    test_rst_in_drain();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
